// File: rtl/io_bridge_pkg.sv
// Shared I/O map for the CPU memory bus: page tag, register addresses and the
// address decoder that every bus-facing block agrees on.
package io_bridge_pkg;

  localparam logic [19:0] IO_PAGE    = 20'hFFFFF;
  localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

  typedef enum logic [2:0] {
    SEL_DRAM,
    SEL_DIG,
    SEL_TIMER,
    SEL_LED,
    SEL_SW,
    SEL_BTN,
    SEL_NONE
  } sel_e;

  // Byte lanes are ignored: only word addresses [11:2] pick a register.
  function automatic sel_e decode_addr(input logic [31:0] addr);
    sel_e sel;
    if (addr[31:12] != IO_PAGE)             sel = SEL_DRAM;
    else if (addr[11:2] == ADDR_DIG[11:2])   sel = SEL_DIG;
    else if (addr[11:2] == ADDR_TIMER[11:2]) sel = SEL_TIMER;
    else if (addr[11:2] == ADDR_LED[11:2])   sel = SEL_LED;
    else if (addr[11:2] == ADDR_SW[11:2])    sel = SEL_SW;
    else if (addr[11:2] == ADDR_BTN[11:2])   sel = SEL_BTN;
    else                                     sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/io_bridge_seg7_decode.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped bridge below the CPU MEM stage: steers accesses to data RAM or
// on-board I/O and owns LED, display scan, timer and input synchronizer state.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  sel_e        sel;
  logic        unused_addr_bits;
  logic [31:0] disp_q, disp_nxt;
  logic [31:0] timer_q, pre_q, scan_q;
  logic [23:0] led_q, sw_s1, sw_s2;
  logic [4:0]  btn_s1, btn_s2;
  logic [2:0]  idx_q, idx_nxt;
  logic [7:0]  dig_en_q, seg_q;
  logic [6:0]  glyph;
  logic        scan_wrap, tick;

  assign sel              = decode_addr(Bus_addr);
  assign unused_addr_bits = ^Bus_addr[1:0];

  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen && (sel == SEL_DRAM);

  // NOTE: always_comb assigns a default before the case so no path can hold a stale value and infer a latch.
  always_comb begin
    Bus_rdata = '0;
    unique case (sel)
      SEL_DRAM:  Bus_rdata = dram_rdata;
      SEL_DIG:   Bus_rdata = disp_q;
      SEL_TIMER: Bus_rdata = timer_q;
      SEL_LED:   Bus_rdata = {8'h00, led_q};
      SEL_SW:    Bus_rdata = {8'h00, sw_s2};
      SEL_BTN:   Bus_rdata = {27'h0, btn_s2};
      default:   Bus_rdata = '0;
    endcase
  end

  assign scan_wrap = (scan_q == 32'(SCAN_DIV - 1));
  assign tick      = (pre_q == 32'(TIMER_DIV - 1));
  assign idx_nxt   = scan_wrap ? idx_q + 3'd1 : idx_q;
  assign disp_nxt  = (Bus_wen && sel == SEL_DIG) ? Bus_wdata : disp_q;

  // Decode the digit that will be lit after this edge so seg/dig_en stay registered yet aligned.
  seg7_decode u_seg7_decode (
    .nibble (disp_nxt[{idx_nxt, 2'b00} +: 4]),
    .seg    (glyph)
  );

  // NOTE: every register below uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      disp_q   <= '0;
      led_q    <= '0;
      timer_q  <= '0;
      pre_q    <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      dig_en_q <= 8'hFE;
      seg_q    <= 8'hC0;
    end else begin
      disp_q <= disp_nxt;
      if (Bus_wen && sel == SEL_LED) led_q <= Bus_wdata[23:0];

      // A bus write wins over a coincident tick and restarts the prescaler.
      if (Bus_wen && sel == SEL_TIMER) begin
        timer_q <= Bus_wdata;
        pre_q   <= '0;
      end else if (tick) begin
        timer_q <= timer_q + 32'd1;
        pre_q   <= '0;
      end else begin
        pre_q <= pre_q + 32'd1;
      end

      scan_q   <= scan_wrap ? '0 : scan_q + 32'd1;
      idx_q    <= idx_nxt;
      dig_en_q <= ~(8'h01 << idx_nxt);
      seg_q    <= {1'b1, glyph};

      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= button;
      btn_s2 <= btn_s1;
    end
  end

  assign led    = led_q;
  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule
